// File: rtl/friscv_pkg.sv
// Shared FRiscV definitions: opcodes, ALU operations, controller states and mux select encodings.
package friscv_pkg;

    localparam logic [6:0] OP_REG       = 7'h33;
    localparam logic [6:0] OP_IMM_ARITH = 7'h13;
    localparam logic [6:0] OP_IMM_LOAD  = 7'h03;
    localparam logic [6:0] OP_STORE     = 7'h23;
    localparam logic [6:0] OP_BRANCH    = 7'h63;
    localparam logic [6:0] OP_JUMP      = 7'h6F;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    typedef enum logic [3:0] {
        ST_RST      = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEMADR   = 4'd3,
        ST_MEMREAD  = 4'd4,
        ST_MEMWB    = 4'd5,
        ST_MEMWRITE = 4'd6,
        ST_EXEC_R   = 4'd7,
        ST_EXEC_I   = 4'd8,
        ST_ALUWB    = 4'd9,
        ST_BEQ      = 4'd10,
        ST_JAL      = 4'd11,
        ST_TRAP     = 4'd12
    } mc_state_t;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    localparam logic [1:0] SRC_B_RS2   = 2'b00;
    localparam logic [1:0] SRC_B_IMM   = 2'b01;
    localparam logic [1:0] SRC_B_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    function automatic logic is_known_op(input logic [6:0] op);
        return (op == OP_REG)      || (op == OP_IMM_ARITH) || (op == OP_IMM_LOAD) ||
               (op == OP_STORE)    || (op == OP_BRANCH)    || (op == OP_JUMP);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode from opcode/func3/func7 for R-type and I-type arithmetic.
module alu_decoder
    import friscv_pkg::*;
(
    input  logic [6:0] i_op_code,
    input  logic [2:0] i_func3,
    input  logic [6:0] i_func7,
    output alu_op_t    o_alu_ctrl
);

    logic w_unused_func7;
    assign w_unused_func7 = ^{i_func7[6], i_func7[4:0]};

    // Only the register form distinguishes add/sub; addi never subtracts.
    always_comb begin
        o_alu_ctrl = ALU_ADD;
        if ((i_op_code == OP_REG) || (i_op_code == OP_IMM_ARITH)) begin
            case (i_func3)
                3'd0: o_alu_ctrl = ((i_op_code == OP_REG) && i_func7[5]) ? ALU_SUB : ALU_ADD;
                3'd1: o_alu_ctrl = ALU_SLL;
                3'd2: o_alu_ctrl = ALU_SLT;
                3'd3: o_alu_ctrl = ALU_SLTU;
                3'd4: o_alu_ctrl = ALU_XOR;
                3'd5: o_alu_ctrl = i_func7[5] ? ALU_SRA : ALU_SRL;
                3'd6: o_alu_ctrl = ALU_OR;
                3'd7: o_alu_ctrl = ALU_AND;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle Moore control FSM for the shared-memory FRiscV datapath.
// Define FRISCV_ILLEGAL_TRAP_EN to trap (sticky) on unknown opcodes; otherwise they retire as NOPs.
module multicycle_controller
    import friscv_pkg::*;
#(
    parameter int ALU_CTRL_W = 4,
    parameter int SEL_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            op_code_in,
    input  logic [2:0]            func3_in,
    input  logic [6:0]            func7_in,
    input  logic                  zero_in,
    input  logic                  mem_ready_in,
    output logic                  mem_req_out,
    output logic                  mem_we_out,
    output logic                  adr_src_out,
    output logic                  ir_write_out,
    output logic                  pc_write_out,
    output logic                  reg_write_out,
    output logic [SEL_W-1:0]      alu_src_a_out,
    output logic [SEL_W-1:0]      alu_src_b_out,
    output logic [ALU_CTRL_W-1:0] alu_ctrl_out,
    output logic [SEL_W-1:0]      result_src_out,
    output logic                  instr_done_out,
    output logic                  illegal_instr_out
);

    mc_state_t r_state;
    mc_state_t w_next_state;
    alu_op_t   w_dec_alu;
    alu_op_t   w_alu;
    logic [1:0] w_src_a;
    logic [1:0] w_src_b;
    logic [1:0] w_res;
    logic      w_mem_req;
    logic      w_mem_we;
    logic      w_adr_src;
    logic      w_ir_write;
    logic      w_pc_write;
    logic      w_reg_write;
    logic      w_done;
    logic      w_illegal;

    alu_decoder u_alu_decoder (
        .i_op_code  (op_code_in),
        .i_func3    (func3_in),
        .i_func7    (func7_in),
        .o_alu_ctrl (w_dec_alu)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RST;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RST:      w_next_state = ST_FETCH;
            ST_FETCH:    if (mem_ready_in) w_next_state = ST_DECODE;
            ST_DECODE: begin
                case (op_code_in)
                    OP_IMM_LOAD,
                    OP_STORE:     w_next_state = ST_MEMADR;
                    OP_REG:       w_next_state = ST_EXEC_R;
                    OP_IMM_ARITH: w_next_state = ST_EXEC_I;
                    OP_BRANCH:    w_next_state = ST_BEQ;
                    OP_JUMP:      w_next_state = ST_JAL;
`ifdef FRISCV_ILLEGAL_TRAP_EN
                    default:      w_next_state = ST_TRAP;
`else
                    default:      w_next_state = ST_FETCH;
`endif
                endcase
            end
            ST_MEMADR:   w_next_state = (op_code_in == OP_IMM_LOAD) ? ST_MEMREAD : ST_MEMWRITE;
            ST_MEMREAD:  if (mem_ready_in) w_next_state = ST_MEMWB;
            ST_MEMWB:    w_next_state = ST_FETCH;
            ST_MEMWRITE: if (mem_ready_in) w_next_state = ST_FETCH;
            ST_EXEC_R,
            ST_EXEC_I:   w_next_state = ST_ALUWB;
            ST_ALUWB:    w_next_state = ST_FETCH;
            ST_BEQ:      w_next_state = ST_FETCH;
            ST_JAL:      w_next_state = ST_ALUWB;
            ST_TRAP:     w_next_state = ST_TRAP;
            default:     w_next_state = ST_RST;
        endcase
    end

    // Moore decode; only the write enables and retire pulse look at ready/zero.
    always_comb begin
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        w_adr_src   = 1'b0;
        w_ir_write  = 1'b0;
        w_pc_write  = 1'b0;
        w_reg_write = 1'b0;
        w_src_a     = SRC_A_PC;
        w_src_b     = SRC_B_RS2;
        w_res       = RES_ALUOUT;
        w_alu       = ALU_ADD;
        w_done      = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_mem_req  = 1'b1;
                w_src_a    = SRC_A_PC;
                w_src_b    = SRC_B_FOUR;
                w_res      = RES_ALU;
                w_ir_write = mem_ready_in;
                w_pc_write = mem_ready_in;
            end
            ST_DECODE: begin
                w_src_a = SRC_A_OLDPC;
                w_src_b = SRC_B_IMM;
`ifndef FRISCV_ILLEGAL_TRAP_EN
                w_done  = !is_known_op(op_code_in);
`endif
            end
            ST_MEMADR: begin
                w_src_a = SRC_A_RS1;
                w_src_b = SRC_B_IMM;
            end
            ST_MEMREAD: begin
                w_mem_req = 1'b1;
                w_adr_src = 1'b1;
            end
            ST_MEMWB: begin
                w_res       = RES_MEMDATA;
                w_reg_write = 1'b1;
                w_done      = 1'b1;
            end
            ST_MEMWRITE: begin
                w_mem_req = 1'b1;
                w_mem_we  = 1'b1;
                w_adr_src = 1'b1;
                w_done    = mem_ready_in;
            end
            ST_EXEC_R: begin
                w_src_a = SRC_A_RS1;
                w_src_b = SRC_B_RS2;
                w_alu   = w_dec_alu;
            end
            ST_EXEC_I: begin
                w_src_a = SRC_A_RS1;
                w_src_b = SRC_B_IMM;
                w_alu   = w_dec_alu;
            end
            ST_ALUWB: begin
                w_res       = RES_ALUOUT;
                w_reg_write = 1'b1;
                w_done      = 1'b1;
            end
            ST_BEQ: begin
                w_src_a    = SRC_A_RS1;
                w_src_b    = SRC_B_RS2;
                w_alu      = ALU_SUB;
                w_res      = RES_ALUOUT;
                w_pc_write = zero_in;
                w_done     = 1'b1;
            end
            ST_JAL: begin
                w_src_a    = SRC_A_OLDPC;
                w_src_b    = SRC_B_FOUR;
                w_res      = RES_ALUOUT;
                w_pc_write = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef FRISCV_ILLEGAL_TRAP_EN
    assign w_illegal = (r_state == ST_TRAP);
`else
    assign w_illegal = 1'b0;
`endif

    assign mem_req_out       = w_mem_req;
    assign mem_we_out        = w_mem_we;
    assign adr_src_out       = w_adr_src;
    assign ir_write_out      = w_ir_write;
    assign pc_write_out      = w_pc_write;
    assign reg_write_out     = w_reg_write;
    assign alu_src_a_out     = SEL_W'(w_src_a);
    assign alu_src_b_out     = SEL_W'(w_src_b);
    assign alu_ctrl_out      = ALU_CTRL_W'(w_alu);
    assign result_src_out    = SEL_W'(w_res);
    assign instr_done_out    = w_done;
    assign illegal_instr_out = w_illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: each stimulus cycle queues its hand-computed output
// vector, a negedge monitor pops and compares. Honours FRISCV_ILLEGAL_TRAP_EN.
module tb_multicycle_controller;

    // Output vector order: illegal, done, result, alu, srcB, srcA, regWrite, pcWrite, irWrite, adrSrc, memWe, memReq
    typedef struct packed {
        logic       illegal;
        logic       done;
        logic [1:0] res;
        logic [3:0] alu;
        logic [1:0] srcB;
        logic [1:0] srcA;
        logic       regWrite;
        logic       pcWrite;
        logic       irWrite;
        logic       adrSrc;
        logic       memWe;
        logic       memReq;
    } outVec_t;

    localparam outVec_t E_RST        = {1'b0, 1'b0, 2'b00, 4'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam outVec_t E_FETCH_WAIT = {1'b0, 1'b0, 2'b10, 4'd0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam outVec_t E_FETCH_GO   = {1'b0, 1'b0, 2'b10, 4'd0, 2'b10, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    localparam outVec_t E_DECODE     = {1'b0, 1'b0, 2'b00, 4'd0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam outVec_t E_DECODE_NOP = {1'b0, 1'b1, 2'b00, 4'd0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam outVec_t E_MEMADR     = {1'b0, 1'b0, 2'b00, 4'd0, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam outVec_t E_MEMREAD    = {1'b0, 1'b0, 2'b00, 4'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    localparam outVec_t E_MEMWB      = {1'b0, 1'b1, 2'b01, 4'd0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam outVec_t E_MEMWR_WAIT = {1'b0, 1'b0, 2'b00, 4'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam outVec_t E_MEMWR_GO   = {1'b0, 1'b1, 2'b00, 4'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam outVec_t E_EXR_ADD    = {1'b0, 1'b0, 2'b00, 4'd0, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam outVec_t E_EXR_SUB    = {1'b0, 1'b0, 2'b00, 4'd1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam outVec_t E_EXR_AND    = {1'b0, 1'b0, 2'b00, 4'd9, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam outVec_t E_EXI_ADD    = {1'b0, 1'b0, 2'b00, 4'd0, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam outVec_t E_EXI_SRA    = {1'b0, 1'b0, 2'b00, 4'd7, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam outVec_t E_ALUWB      = {1'b0, 1'b1, 2'b00, 4'd0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam outVec_t E_BEQ_TAKEN  = {1'b0, 1'b1, 2'b00, 4'd1, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam outVec_t E_BEQ_NOT    = {1'b0, 1'b1, 2'b00, 4'd1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam outVec_t E_JAL        = {1'b0, 1'b0, 2'b00, 4'd0, 2'b10, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam outVec_t E_TRAP       = {1'b1, 1'b0, 2'b00, 4'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op_code_in;
    logic [2:0] func3_in;
    logic [6:0] func7_in;
    logic       zero_in;
    logic       mem_ready_in;
    logic       mem_req_out, mem_we_out, adr_src_out, ir_write_out, pc_write_out, reg_write_out;
    logic [1:0] alu_src_a_out, alu_src_b_out, result_src_out;
    logic [3:0] alu_ctrl_out;
    logic       instr_done_out, illegal_instr_out;

    outVec_t    actual;
    outVec_t    expQ[$];
    string      nameQ[$];
    int         checkCount = 0;
    int         failCount  = 0;

    logic [6:0] curOp = 7'h00;
    logic [2:0] curF3 = 3'd0;
    logic [6:0] curF7 = 7'h00;
    logic       curZero = 1'b0;

    multicycle_controller #(.ALU_CTRL_W(4), .SEL_W(2)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .op_code_in        (op_code_in),
        .func3_in          (func3_in),
        .func7_in          (func7_in),
        .zero_in           (zero_in),
        .mem_ready_in      (mem_ready_in),
        .mem_req_out       (mem_req_out),
        .mem_we_out        (mem_we_out),
        .adr_src_out       (adr_src_out),
        .ir_write_out      (ir_write_out),
        .pc_write_out      (pc_write_out),
        .reg_write_out     (reg_write_out),
        .alu_src_a_out     (alu_src_a_out),
        .alu_src_b_out     (alu_src_b_out),
        .alu_ctrl_out      (alu_ctrl_out),
        .result_src_out    (result_src_out),
        .instr_done_out    (instr_done_out),
        .illegal_instr_out (illegal_instr_out)
    );

    always #5 clk = ~clk;

    assign actual = {illegal_instr_out, instr_done_out, result_src_out, alu_ctrl_out,
                     alu_src_b_out, alu_src_a_out, reg_write_out, pc_write_out,
                     ir_write_out, adr_src_out, mem_we_out, mem_req_out};

    task automatic setInstr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input logic zero);
        curOp   = op;
        curF3   = f3;
        curF7   = f7;
        curZero = zero;
    endtask

    // One cycle of stimulus: drive just after the rising edge and queue what this cycle must show.
    task automatic applyStimulus(input string name, input logic ready, input logic rstN, input outVec_t exp);
        @(posedge clk);
        #1;
        rst_n        = rstN;
        op_code_in   = curOp;
        func3_in     = curF3;
        func7_in     = curF7;
        zero_in      = curZero;
        mem_ready_in = ready;
        expQ.push_back(exp);
        nameQ.push_back(name);
    endtask

    task automatic checkOutput(input string name, input outVec_t act, input outVec_t exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: actual=%05h required=%05h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (expQ.size() != 0) begin
            checkOutput(nameQ.pop_front(), actual, expQ.pop_front());
        end
    end

    initial begin
        rst_n        = 1'b0;
        op_code_in   = 7'h00;
        func3_in     = 3'd0;
        func7_in     = 7'h00;
        zero_in      = 1'b0;
        mem_ready_in = 1'b0;

        applyStimulus("reset_held",    1'b0, 1'b0, E_RST);
        applyStimulus("reset_release", 1'b0, 1'b1, E_RST);

        // add with a two-cycle fetch stall
        setInstr(7'h33, 3'd0, 7'h00, 1'b0);
        applyStimulus("add_fetch_wait0", 1'b0, 1'b1, E_FETCH_WAIT);
        applyStimulus("add_fetch_wait1", 1'b0, 1'b1, E_FETCH_WAIT);
        applyStimulus("add_fetch",       1'b1, 1'b1, E_FETCH_GO);
        applyStimulus("add_decode",      1'b1, 1'b1, E_DECODE);
        applyStimulus("add_exec",        1'b1, 1'b1, E_EXR_ADD);
        applyStimulus("add_aluwb",       1'b1, 1'b1, E_ALUWB);

        setInstr(7'h33, 3'd0, 7'h20, 1'b0);
        applyStimulus("sub_fetch",  1'b1, 1'b1, E_FETCH_GO);
        applyStimulus("sub_decode", 1'b1, 1'b1, E_DECODE);
        applyStimulus("sub_exec",   1'b1, 1'b1, E_EXR_SUB);
        applyStimulus("sub_aluwb",  1'b1, 1'b1, E_ALUWB);

        setInstr(7'h33, 3'd7, 7'h00, 1'b0);
        applyStimulus("and_fetch",  1'b1, 1'b1, E_FETCH_GO);
        applyStimulus("and_decode", 1'b1, 1'b1, E_DECODE);
        applyStimulus("and_exec",   1'b1, 1'b1, E_EXR_AND);
        applyStimulus("and_aluwb",  1'b1, 1'b1, E_ALUWB);

        // lw with three not-ready cycles in MEMREAD: eight cycles total
        setInstr(7'h03, 3'd2, 7'h00, 1'b0);
        applyStimulus("lw_fetch",    1'b1, 1'b1, E_FETCH_GO);
        applyStimulus("lw_decode",   1'b1, 1'b1, E_DECODE);
        applyStimulus("lw_memadr",   1'b1, 1'b1, E_MEMADR);
        for (int i = 0; i < 3; i++) applyStimulus("lw_memread_wait", 1'b0, 1'b1, E_MEMREAD);
        applyStimulus("lw_memread",  1'b1, 1'b1, E_MEMREAD);
        applyStimulus("lw_memwb",    1'b1, 1'b1, E_MEMWB);

        setInstr(7'h23, 3'd2, 7'h00, 1'b0);
        applyStimulus("sw_fetch",         1'b1, 1'b1, E_FETCH_GO);
        applyStimulus("sw_decode",        1'b1, 1'b1, E_DECODE);
        applyStimulus("sw_memadr",        1'b1, 1'b1, E_MEMADR);
        applyStimulus("sw_memwrite_wait", 1'b0, 1'b1, E_MEMWR_WAIT);
        applyStimulus("sw_memwrite",      1'b1, 1'b1, E_MEMWR_GO);

        setInstr(7'h63, 3'd0, 7'h00, 1'b1);
        applyStimulus("beq_t_fetch",  1'b1, 1'b1, E_FETCH_GO);
        applyStimulus("beq_t_decode", 1'b1, 1'b1, E_DECODE);
        applyStimulus("beq_taken",    1'b1, 1'b1, E_BEQ_TAKEN);
        setInstr(7'h63, 3'd0, 7'h00, 1'b0);
        applyStimulus("beq_n_fetch",  1'b1, 1'b1, E_FETCH_GO);
        applyStimulus("beq_n_decode", 1'b1, 1'b1, E_DECODE);
        applyStimulus("beq_not",      1'b1, 1'b1, E_BEQ_NOT);

        // addi ignores func7[5]; srai honours it
        setInstr(7'h13, 3'd0, 7'h20, 1'b0);
        applyStimulus("addi_fetch",  1'b1, 1'b1, E_FETCH_GO);
        applyStimulus("addi_decode", 1'b1, 1'b1, E_DECODE);
        applyStimulus("addi_exec",   1'b1, 1'b1, E_EXI_ADD);
        applyStimulus("addi_aluwb",  1'b1, 1'b1, E_ALUWB);
        setInstr(7'h13, 3'd5, 7'h20, 1'b0);
        applyStimulus("srai_fetch",  1'b1, 1'b1, E_FETCH_GO);
        applyStimulus("srai_decode", 1'b1, 1'b1, E_DECODE);
        applyStimulus("srai_exec",   1'b1, 1'b1, E_EXI_SRA);
        applyStimulus("srai_aluwb",  1'b1, 1'b1, E_ALUWB);

        setInstr(7'h6F, 3'd0, 7'h00, 1'b0);
        applyStimulus("jal_fetch",  1'b1, 1'b1, E_FETCH_GO);
        applyStimulus("jal_decode", 1'b1, 1'b1, E_DECODE);
        applyStimulus("jal_exec",   1'b1, 1'b1, E_JAL);
        applyStimulus("jal_aluwb",  1'b1, 1'b1, E_ALUWB);

        // Asynchronous reset in the middle of a stalled load
        setInstr(7'h03, 3'd2, 7'h00, 1'b0);
        applyStimulus("rstlw_fetch",    1'b1, 1'b1, E_FETCH_GO);
        applyStimulus("rstlw_decode",   1'b1, 1'b1, E_DECODE);
        applyStimulus("rstlw_memadr",   1'b1, 1'b1, E_MEMADR);
        applyStimulus("rstlw_memread",  1'b0, 1'b1, E_MEMREAD);
        applyStimulus("rstlw_midreset", 1'b0, 1'b0, E_RST);
        applyStimulus("rstlw_release",  1'b0, 1'b1, E_RST);
        applyStimulus("rstlw_refetch",  1'b0, 1'b1, E_FETCH_WAIT);
        applyStimulus("rstlw_fetch2",   1'b1, 1'b1, E_FETCH_GO);
        applyStimulus("rstlw_decode2",  1'b1, 1'b1, E_DECODE);
        applyStimulus("rstlw_memadr2",  1'b1, 1'b1, E_MEMADR);
        applyStimulus("rstlw_memread2", 1'b1, 1'b1, E_MEMREAD);
        applyStimulus("rstlw_memwb2",   1'b1, 1'b1, E_MEMWB);

        setInstr(7'h7F, 3'd0, 7'h00, 1'b0);
        applyStimulus("ill_fetch",  1'b1, 1'b1, E_FETCH_GO);
`ifdef FRISCV_ILLEGAL_TRAP_EN
        applyStimulus("ill_decode", 1'b1, 1'b1, E_DECODE);
        for (int i = 0; i < 20; i++) applyStimulus("ill_trap", 1'b1, 1'b1, E_TRAP);
        applyStimulus("trap_reset",   1'b1, 1'b0, E_RST);
        applyStimulus("trap_release", 1'b1, 1'b1, E_RST);
        applyStimulus("trap_refetch", 1'b1, 1'b1, E_FETCH_GO);
`else
        applyStimulus("ill_decode_nop", 1'b1, 1'b1, E_DECODE_NOP);
        applyStimulus("ill_refetch",    1'b1, 1'b1, E_FETCH_GO);
`endif

        for (int i = 0; i < 10 && expQ.size() != 0; i++) @(negedge clk);
        #1;
        if (expQ.size() != 0) begin
            checkCount++;
            failCount++;
            $display("[TB] FAIL drain: pending=%0d required=0", expQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
